adc_frame_scheduler: RTL and testbench
======================================

# adc_frame_scheduler

Per-frame sampling scheduler between the free-running dual-channel 8-bit ADC front end and the pong game logic. On each frame tick it opens a capture window and collects a fixed number of completed ADC conversions per channel, using the converter's BUSY falling edge as the completion event. It averages each channel, scales the average to the paddle travel range and applies hysteresis. It then presents both paddle positions to the game logic under a valid/ack handshake and flags a stalled converter via a watchdog.

## Interface
- SAMPLES_LOG2, 2: log2 of conversions averaged per frame (1..4).
- PAD_MAX, 8'd200: paddle Y range; output = avg*PAD_MAX>>8.
- HYST, 8'd2: output updates only if |new-old| > HYST.
- TIMEOUT, 16'd4096: max CLOCK_50MHz cycles between conversion completions inside a window.
- CLOCK_50MHz  in  1  system clock.
- RESET_n  in  1  synchronous, active-low reset.
- FRAME_TICK  in  1  one-cycle start-of-frame pulse.
- BUSY  in  1  converter busy; high during conversion; treated as asynchronous.
- DATA_AD0, DATA_AD1  in  8 each  converter results; stable from BUSY fall until the next conversion ends.
- PAD_ACK  in  1  game logic consumed positions.
- PAD_VALID  out  1  positions valid; reset 0.
- PAD0_Y, PAD1_Y  out  8 each  paddle positions; reset PAD_MAX>>1.
- SCHED_BUSY  out  1  high when state != IDLE; reset 0.
- ADC_FAULT  out  1  sticky watchdog flag; reset 0.
- OVERRUN  out  1  one-cycle pulse on FRAME_TICK while not IDLE; reset 0.

## Operation
- BUSY passes through a 2-flop synchronizer (q1, q2). A completion event is q2=1 and q1=0, combinational from the synchronizer flops.
- IDLE: on FRAME_TICK, clear both accumulators, sample counter and watchdog, then go to ACC.
- ACC: on each completion event, add DATA_AD0 and DATA_AD1 into the 8+SAMPLES_LOG2-bit accumulators and increment the sample counter. The watchdog increments every cycle and clears on each event.
  - Event that makes the count equal 2^SAMPLES_LOG2: go to SCALE.
  - Watchdog reaches TIMEOUT-1: set ADC_FAULT, go to IDLE. PAD_VALID is not asserted and outputs hold.
- SCALE: avg = acc >> SAMPLES_LOG2. Register prod = avg*PAD_MAX (16 bit, unsigned). Go to UPDATE.
- UPDATE: cand = prod[15:8]. For each channel independently, if |cand - PADn_Y| > HYST then PADn_Y <= cand, else hold. Assert PAD_VALID, clear ADC_FAULT, go to PRESENT.
- PRESENT: hold PAD_VALID and both outputs stable until the cycle PAD_ACK=1. On that cycle, deassert PAD_VALID the next cycle and go to IDLE.
- FRAME_TICK in any state other than IDLE: pulse OVERRUN and do not change state. The tick is dropped, not queued.
- FRAME_TICK and the ACK cycle of PRESENT together: OVERRUN pulses, and the next frame waits for the following tick.
- PAD_ACK outside PRESENT is ignored.
- Completion events outside ACC are ignored. The synchronizer runs continuously.
- Reset mid-operation, any state: IDLE, accumulators 0, outputs return to their reset values. Synchronizer flops reset to 0.

## Timing
- Completion detected at clock edge T (capture edge).
  - Nth capture at T: SCALE at T+1, UPDATE at T+2.
  - PAD_VALID high and new PADn_Y visible after edge T+2.
- Input to capture: 2-3 cycles after the raw BUSY fall, from the synchronizer.
- PAD_ACK high at edge A: PAD_VALID low after A, state IDLE after A. The earliest next accepted FRAME_TICK is at edge A+1.
- Arithmetic is unsigned throughout. No saturation is needed: the maximum product 255*255 fits in 16 bits.
- The watchdog is 16 bits and never wraps, because it forces an exit at TIMEOUT-1.

## Structure
- Shared package pong_pkg holds:
  - state enum: IDLE, ACC, SCALE, UPDATE, PRESENT.
  - PAD_W=8 and default PAD_MAX, HYST and TIMEOUT constants.
- Sub-module paddle_chan, instantiated twice, holds the per-channel accumulator, scale multiply and hysteresis register.
- The top level holds the synchronizer, FSM, sample counter, watchdog and flags.

## Test plan
- Ch0 samples 100,102,104,106 and ch1 samples 255 x4, with PAD_MAX=200 -> PAD0_Y=80, PAD1_Y=199. PAD_VALID rises 2 cycles after the 4th capture.
- Next frame, ch0 104 x4 (cand 81) -> PAD0_Y holds 80 (within HYST). Ch1 0 x4 -> PAD1_Y=0.
- BUSY held low after FRAME_TICK -> ADC_FAULT=1 after exactly 4096 cycles, IDLE, PAD_VALID never asserted. The next good frame clears ADC_FAULT.
- FRAME_TICK during ACC and during PRESENT -> one-cycle OVERRUN each time, capture count unaffected. PAD_ACK delayed 50 cycles -> outputs stable throughout.
- RESET_n low for 1 cycle after the 2nd capture -> PAD0_Y=PAD1_Y=100, PAD_VALID=0, SCHED_BUSY=0. A fresh frame after reset needs a full 4 samples.
- BUSY glitch-free pulses arriving every 136 cycles -> exactly one capture per fall, with no double counting across the synchronizer.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and defaults for the ADC frame scheduler
package pong_pkg;

    localparam int unsigned PAD_W = 8;

    localparam logic [PAD_W-1:0] DEF_PAD_MAX = 8'd200;
    localparam logic [PAD_W-1:0] DEF_HYST    = 8'd2;
    localparam logic [15:0]      DEF_TIMEOUT = 16'd4096;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        SCALE,
        UPDATE,
        PRESENT
    } sched_state_e;

    // Unsigned distance between two paddle positions
    function automatic logic [PAD_W-1:0] abs_diff(input logic [PAD_W-1:0] a,
                                                  input logic [PAD_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/paddle_chan.sv
// rtl/paddle_chan.sv - per-channel accumulator, scale multiply and hysteresis register
module paddle_chan
    import pong_pkg::*;
#(
    parameter int unsigned        SAMPLES_LOG2 = 2,
    parameter logic [PAD_W-1:0]   PAD_MAX      = DEF_PAD_MAX,
    parameter logic [PAD_W-1:0]   HYST         = DEF_HYST
) (
    input  logic             CLOCK_50MHz,
    input  logic             RESET_n,
    input  logic             clear_i,
    input  logic             add_i,
    input  logic             scale_i,
    input  logic             update_i,
    input  logic [PAD_W-1:0] data_i,
    output logic [PAD_W-1:0] pad_y_o
);

    localparam int unsigned ACC_W  = PAD_W + SAMPLES_LOG2;
    localparam int unsigned PROD_W = 2 * PAD_W;

    logic [ACC_W-1:0]  acc_q,  acc_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [PAD_W-1:0]  y_q,    y_d;
    logic [PAD_W-1:0]  avg;
    logic [PAD_W-1:0]  cand;

    // Next-state: accumulate, scale the average, then apply hysteresis
    always_comb begin
        acc_d  = acc_q;
        prod_d = prod_q;
        y_d    = y_q;
        avg    = PAD_W'(acc_q >> SAMPLES_LOG2);
        cand   = PAD_W'(prod_q >> PAD_W);
        if (clear_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + ACC_W'(data_i);
        end
        if (scale_i) begin
            prod_d = PROD_W'(avg) * PROD_W'(PAD_MAX);
        end
        if (update_i && (abs_diff(cand, y_q) > HYST)) begin
            y_d = cand;
        end
    end

    // Channel registers; the paddle rests mid-range out of reset
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            acc_q  <= '0;
            prod_q <= '0;
            y_q    <= PAD_MAX >> 1;
        end else begin
            acc_q  <= acc_d;
            prod_q <= prod_d;
            y_q    <= y_d;
        end
    end

    assign pad_y_o = y_q;

endmodule

// File: rtl/adc_frame_scheduler.sv
// rtl/adc_frame_scheduler.sv - per-frame ADC capture, averaging and paddle handshake
module adc_frame_scheduler
    import pong_pkg::*;
#(
    parameter int unsigned        SAMPLES_LOG2 = 2,
    parameter logic [PAD_W-1:0]   PAD_MAX      = DEF_PAD_MAX,
    parameter logic [PAD_W-1:0]   HYST         = DEF_HYST,
    parameter logic [15:0]        TIMEOUT      = DEF_TIMEOUT
) (
    input  logic             CLOCK_50MHz,
    input  logic             RESET_n,
    input  logic             FRAME_TICK,
    input  logic             BUSY,
    input  logic [PAD_W-1:0] DATA_AD0,
    input  logic [PAD_W-1:0] DATA_AD1,
    input  logic             PAD_ACK,
    output logic             PAD_VALID,
    output logic [PAD_W-1:0] PAD0_Y,
    output logic [PAD_W-1:0] PAD1_Y,
    output logic             SCHED_BUSY,
    output logic             ADC_FAULT,
    output logic             OVERRUN
);

    localparam int unsigned          CNT_W    = SAMPLES_LOG2 + 1;
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'((1 << SAMPLES_LOG2) - 1);

    sched_state_e      state_q, state_d;
    logic              busy_q1, busy_q2;
    logic              capture;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       wd_q, wd_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              overrun_q, overrun_d;
    logic              clear_acc, add_en, scale_en, update_en;

    // BUSY is asynchronous; two flops before edge detection, always running
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            busy_q1 <= 1'b0;
            busy_q2 <= 1'b0;
        end else begin
            busy_q1 <= BUSY;
            busy_q2 <= busy_q1;
        end
    end

    // Conversion completion is the synchronized BUSY falling edge
    assign capture = busy_q2 & ~busy_q1;

    // Next-state and datapath strobes for the frame sequence
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        overrun_d = FRAME_TICK && (state_q != IDLE);
        clear_acc = 1'b0;
        add_en    = 1'b0;
        scale_en  = 1'b0;
        update_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (FRAME_TICK) begin
                    clear_acc = 1'b1;
                    cnt_d     = '0;
                    wd_d      = '0;
                    state_d   = ACC;
                end
            end
            ACC: begin
                if (capture) begin
                    add_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    wd_d   = '0;
                    if (cnt_q == LAST_CNT) begin
                        state_d = SCALE;
                    end
                end else if (wd_q == (TIMEOUT - 16'd1)) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            SCALE: begin
                scale_en = 1'b1;
                state_d  = UPDATE;
            end
            UPDATE: begin
                update_en = 1'b1;
                valid_d   = 1'b1;
                fault_d   = 1'b0;
                state_d   = PRESENT;
            end
            PRESENT: begin
                if (PAD_ACK) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, counters and flags
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wd_q      <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            overrun_q <= overrun_d;
        end
    end

    paddle_chan #(
        .SAMPLES_LOG2 (SAMPLES_LOG2),
        .PAD_MAX      (PAD_MAX),
        .HYST         (HYST)
    ) u_chan0 (
        .CLOCK_50MHz (CLOCK_50MHz),
        .RESET_n     (RESET_n),
        .clear_i     (clear_acc),
        .add_i       (add_en),
        .scale_i     (scale_en),
        .update_i    (update_en),
        .data_i      (DATA_AD0),
        .pad_y_o     (PAD0_Y)
    );

    paddle_chan #(
        .SAMPLES_LOG2 (SAMPLES_LOG2),
        .PAD_MAX      (PAD_MAX),
        .HYST         (HYST)
    ) u_chan1 (
        .CLOCK_50MHz (CLOCK_50MHz),
        .RESET_n     (RESET_n),
        .clear_i     (clear_acc),
        .add_i       (add_en),
        .scale_i     (scale_en),
        .update_i    (update_en),
        .data_i      (DATA_AD1),
        .pad_y_o     (PAD1_Y)
    );

    assign PAD_VALID  = valid_q;
    assign SCHED_BUSY = (state_q != IDLE);
    assign ADC_FAULT  = fault_q;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// tb/tb_adc_frame_scheduler.sv - scoreboard bench for adc_frame_scheduler
module tb_adc_frame_scheduler;

    localparam int N      = 4;
    localparam int PADMAX = 200;
    localparam int HYSTV  = 2;

    logic       CLOCK_50MHz = 1'b0;
    logic       RESET_n     = 1'b0;
    logic       FRAME_TICK  = 1'b0;
    logic       BUSY        = 1'b0;
    logic [7:0] DATA_AD0    = 8'd0;
    logic [7:0] DATA_AD1    = 8'd0;
    logic       PAD_ACK     = 1'b0;
    logic       PAD_VALID;
    logic [7:0] PAD0_Y;
    logic [7:0] PAD1_Y;
    logic       SCHED_BUSY;
    logic       ADC_FAULT;
    logic       OVERRUN;

    typedef struct packed {
        logic [7:0] y0;
        logic [7:0] y1;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   model_y0 = 100;
    int   model_y1 = 100;
    int   s0[N];
    int   s1[N];

    adc_frame_scheduler #(
        .SAMPLES_LOG2 (2),
        .PAD_MAX      (8'd200),
        .HYST         (8'd2),
        .TIMEOUT      (16'd4096)
    ) dut (
        .CLOCK_50MHz (CLOCK_50MHz),
        .RESET_n     (RESET_n),
        .FRAME_TICK  (FRAME_TICK),
        .BUSY        (BUSY),
        .DATA_AD0    (DATA_AD0),
        .DATA_AD1    (DATA_AD1),
        .PAD_ACK     (PAD_ACK),
        .PAD_VALID   (PAD_VALID),
        .PAD0_Y      (PAD0_Y),
        .PAD1_Y      (PAD1_Y),
        .SCHED_BUSY  (SCHED_BUSY),
        .ADC_FAULT   (ADC_FAULT),
        .OVERRUN     (OVERRUN)
    );

    always #10 CLOCK_50MHz = ~CLOCK_50MHz;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int scale_avg(input int sum);
        return ((sum / N) * PADMAX) / 256;
    endfunction

    function automatic int hyst(input int old, input int cand);
        int d;
        d = (cand > old) ? cand - old : old - cand;
        return (d > HYSTV) ? cand : old;
    endfunction

    // Monitor: pops one expectation per PAD_VALID rise and checks hold while valid
    logic       prev_valid = 1'b0;
    logic [7:0] held0      = 8'd0;
    logic [7:0] held1      = 8'd0;
    always @(negedge CLOCK_50MHz) begin : monitor
        exp_t e;
        if (PAD_VALID && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: PAD_VALID rose with no frame expected at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("pad0_y", PAD0_Y, e.y0);
                check("pad1_y", PAD1_Y, e.y1);
            end
            held0 <= PAD0_Y;
            held1 <= PAD1_Y;
        end else if (PAD_VALID && prev_valid) begin
            check("pad0_stable", PAD0_Y, held0);
            check("pad1_stable", PAD1_Y, held1);
        end
        prev_valid <= PAD_VALID;
    end

    // All stimulus tasks start and end on a falling clock edge
    task automatic pulse_tick();
        FRAME_TICK = 1'b1;
        @(negedge CLOCK_50MHz);
        FRAME_TICK = 1'b0;
    endtask

    task automatic conv(input int d0, input int d1, input int busy_w);
        BUSY = 1'b1;
        repeat (busy_w) @(negedge CLOCK_50MHz);
        DATA_AD0 = 8'(d0);
        DATA_AD1 = 8'(d1);
        BUSY     = 1'b0;
    endtask

    task automatic run_frame(input int busy_w, input int low_w, input int ack_dly,
                             input bit ovr_acc, input bit ovr_pres, input bit tick_on_ack);
        int   sum0 = 0;
        int   sum1 = 0;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            sum0 += s0[i];
            sum1 += s1[i];
        end
        model_y0 = hyst(model_y0, scale_avg(sum0));
        model_y1 = hyst(model_y1, scale_avg(sum1));
        e.y0 = 8'(model_y0);
        e.y1 = 8'(model_y1);
        exp_q.push_back(e);
        pulse_tick();
        for (int i = 0; i < N; i++) begin
            conv(s0[i], s1[i], busy_w);
            if (i < N - 1) begin
                repeat (low_w) @(negedge CLOCK_50MHz);
                if (i == 0) begin
                    PAD_ACK = 1'b1;
                    @(negedge CLOCK_50MHz);
                    PAD_ACK = 1'b0;
                end
                if (i == 1 && ovr_acc) begin
                    pulse_tick();
                    check("overrun_acc", OVERRUN, 1);
                    @(negedge CLOCK_50MHz);
                    check("overrun_acc_len", OVERRUN, 0);
                end
            end
        end
        repeat (3) begin
            @(negedge CLOCK_50MHz);
            check("valid_early", PAD_VALID, 0);
        end
        @(negedge CLOCK_50MHz);
        check("valid_latency", PAD_VALID, 1);
        check("fault_cleared", ADC_FAULT, 0);
        repeat (ack_dly) @(negedge CLOCK_50MHz);
        if (ovr_pres) begin
            pulse_tick();
            check("overrun_present", OVERRUN, 1);
            check("valid_hold_tick", PAD_VALID, 1);
        end
        PAD_ACK = 1'b1;
        if (tick_on_ack) FRAME_TICK = 1'b1;
        @(negedge CLOCK_50MHz);
        PAD_ACK    = 1'b0;
        FRAME_TICK = 1'b0;
        check("valid_after_ack", PAD_VALID, 0);
        check("idle_after_ack", SCHED_BUSY, 0);
        if (tick_on_ack) begin
            check("overrun_on_ack", OVERRUN, 1);
            @(negedge CLOCK_50MHz);
            check("tick_dropped", SCHED_BUSY, 0);
        end
    endtask

    initial begin
        int base0;
        int base1;
        repeat (3) @(negedge CLOCK_50MHz);
        check("rst_valid", PAD_VALID, 0);
        check("rst_pad0", PAD0_Y, 100);
        check("rst_pad1", PAD1_Y, 100);
        check("rst_busy", SCHED_BUSY, 0);
        check("rst_fault", ADC_FAULT, 0);
        check("rst_overrun", OVERRUN, 0);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLOCK_50MHz);

        s0 = '{100, 102, 104, 106};
        s1 = '{255, 255, 255, 255};
        run_frame(3, 4, 2, 1'b0, 1'b0, 1'b0);
        check("frame1_pad0", PAD0_Y, 80);
        check("frame1_pad1", PAD1_Y, 199);

        s0 = '{104, 104, 104, 104};
        s1 = '{0, 0, 0, 0};
        run_frame(2, 3, 0, 1'b0, 1'b0, 1'b0);
        check("frame2_pad0_hold", PAD0_Y, 80);
        check("frame2_pad1", PAD1_Y, 0);

        // Converter stalled: BUSY stays low for the whole window
        pulse_tick();
        check("acc_busy", SCHED_BUSY, 1);
        repeat (4095) @(negedge CLOCK_50MHz);
        check("fault_not_yet", ADC_FAULT, 0);
        check("still_acc", SCHED_BUSY, 1);
        @(negedge CLOCK_50MHz);
        check("fault_set", ADC_FAULT, 1);
        check("fault_idle", SCHED_BUSY, 0);
        check("fault_no_valid", PAD_VALID, 0);
        check("fault_pad0_hold", PAD0_Y, 80);
        check("fault_pad1_hold", PAD1_Y, 0);

        s0 = '{40, 50, 60, 70};
        s1 = '{200, 190, 180, 170};
        run_frame(2, 5, 50, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of a window, after two captures
        pulse_tick();
        conv(10, 20, 2);
        repeat (4) @(negedge CLOCK_50MHz);
        conv(30, 40, 2);
        repeat (3) @(negedge CLOCK_50MHz);
        RESET_n = 1'b0;
        @(negedge CLOCK_50MHz);
        RESET_n = 1'b1;
        check("midrst_pad0", PAD0_Y, 100);
        check("midrst_pad1", PAD1_Y, 100);
        check("midrst_valid", PAD_VALID, 0);
        check("midrst_busy", SCHED_BUSY, 0);
        model_y0 = 100;
        model_y1 = 100;
        @(negedge CLOCK_50MHz);
        s0 = '{220, 230, 240, 250};
        s1 = '{5, 6, 7, 8};
        run_frame(3, 3, 1, 1'b0, 1'b0, 1'b0);

        // Slow converter: one conversion every 136 cycles
        s0 = '{128, 129, 130, 131};
        s1 = '{64, 64, 64, 64};
        run_frame(100, 36, 1, 1'b0, 1'b0, 1'b0);

        base0 = 128;
        base1 = 64;
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                base0 = $urandom_range(0, 252);
                base1 = $urandom_range(0, 252);
            end else begin
                base0 = base0 + $urandom_range(0, 6) - 3;
                base1 = base1 + $urandom_range(0, 6) - 3;
                if (base0 < 0) base0 = 0;
                if (base0 > 252) base0 = 252;
                if (base1 < 0) base1 = 0;
                if (base1 > 252) base1 = 252;
            end
            for (int i = 0; i < N; i++) begin
                s0[i] = base0 + $urandom_range(0, 3);
                s1[i] = base1 + $urandom_range(0, 3);
            end
            run_frame($urandom_range(1, 6), $urandom_range(2, 8), $urandom_range(0, 5),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0));
        end

        repeat (10) @(negedge CLOCK_50MHz);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
